// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA timing constants shared by the sync generator and decoder
package vga_timing_pkg;

   localparam int CNT_W         = 12;
   localparam int TOTAL_WIDTH   = 800;
   localparam int TOTAL_HEIGHT  = 525;
   localparam int ACTIVE_WIDTH  = 640;
   localparam int ACTIVE_HEIGHT = 480;
   localparam int H_SYNC_START  = 681;
   localparam int V_SYNC_START  = 501;
   localparam int LOCK_FRAMES   = 2;
   localparam logic SYNC_ACTIVE = 1'b1;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2
   } sync_state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      return (value == CNT_MAX) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - two-flop synchroniser with registered asserted-edge detect
// The edge pulse appears three clocks after the input reaches the asserted level.
module vga_sync_edge
   import vga_timing_pkg::*;
#(
   parameter logic ACTIVE_LEVEL = SYNC_ACTIVE
)
(
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic sync,
   output logic sync_edge
);

   logic r_Meta;
   logic r_Sync;
   logic r_Prev;

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_Meta    <= ~ACTIVE_LEVEL;
         r_Sync    <= ~ACTIVE_LEVEL;
         r_Prev    <= ~ACTIVE_LEVEL;
         sync_edge <= 1'b0;
      end else begin
         r_Meta    <= sync;
         r_Sync    <= r_Meta;
         r_Prev    <= r_Sync;
         sync_edge <= (r_Sync == ACTIVE_LEVEL) && (r_Prev != ACTIVE_LEVEL);
      end
   end

endmodule

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - measures HSync/VSync timing, locks, and regenerates pixel position
// Column/row free-run in every state; the lock FSM only gates the qualified outputs.
module vga_sync_decoder #(
   parameter int   TOTAL_WIDTH   = vga_timing_pkg::TOTAL_WIDTH,
   parameter int   TOTAL_HEIGHT  = vga_timing_pkg::TOTAL_HEIGHT,
   parameter int   ACTIVE_WIDTH  = vga_timing_pkg::ACTIVE_WIDTH,
   parameter int   ACTIVE_HEIGHT = vga_timing_pkg::ACTIVE_HEIGHT,
   parameter int   H_SYNC_START  = vga_timing_pkg::H_SYNC_START,
   parameter int   V_SYNC_START  = vga_timing_pkg::V_SYNC_START,
   parameter logic SYNC_ACTIVE   = vga_timing_pkg::SYNC_ACTIVE,
   parameter int   LOCK_FRAMES   = vga_timing_pkg::LOCK_FRAMES
)
(
   input  logic                             i_Clk,
   input  logic                             i_Rst,
   input  logic                             i_HSync,
   input  logic                             i_VSync,
   output logic [vga_timing_pkg::CNT_W-1:0] o_Col,
   output logic [vga_timing_pkg::CNT_W-1:0] o_Row,
   output logic                             o_Active,
   output logic                             o_Frame_Start,
   output logic                             o_Locked,
   output logic [vga_timing_pkg::CNT_W-1:0] o_Line_Len,
   output logic                             o_Error
);

   import vga_timing_pkg::*;

   localparam logic [CNT_W-1:0] LINE_LEN    = CNT_W'(TOTAL_WIDTH);
   localparam logic [CNT_W-1:0] FRAME_LINES = CNT_W'(TOTAL_HEIGHT);
   localparam logic [CNT_W-1:0] COL_LAST    = CNT_W'(TOTAL_WIDTH - 1);
   localparam logic [CNT_W-1:0] ROW_LAST    = CNT_W'(TOTAL_HEIGHT - 1);
   localparam logic [CNT_W-1:0] ACT_W       = CNT_W'(ACTIVE_WIDTH);
   localparam logic [CNT_W-1:0] ACT_H       = CNT_W'(ACTIVE_HEIGHT);
   localparam logic [CNT_W-1:0] HS_LOAD     = CNT_W'(H_SYNC_START);
   localparam logic [CNT_W-1:0] VS_LOAD     = CNT_W'(V_SYNC_START);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(2 * TOTAL_WIDTH);
   localparam logic [3:0]       LOCK_CNT    = 4'(LOCK_FRAMES);

   logic             hs_edge;
   logic             vs_edge;
   logic [CNT_W-1:0] r_HCnt;
   logic [CNT_W-1:0] r_VCnt;
   logic             r_Lines_Ok;
   logic [CNT_W-1:0] line_len_next;
   logic [CNT_W-1:0] frame_lines;
   logic             line_ok;
   logic             frame_good;
   logic             timeout;
   logic             col_wrap;
   logic             lock_loss;

   sync_state_t      r_State;
   sync_state_t      next_state;
   logic [3:0]       r_Good_Cnt;
   logic [3:0]       good_cnt_next;
   logic             error_next;
   logic             locked_next;

   vga_sync_edge #(.ACTIVE_LEVEL(SYNC_ACTIVE)) u_hs_edge (
      .i_Clk     (i_Clk),
      .i_Rst     (i_Rst),
      .sync      (i_HSync),
      .sync_edge (hs_edge)
   );

   vga_sync_edge #(.ACTIVE_LEVEL(SYNC_ACTIVE)) u_vs_edge (
      .i_Clk     (i_Clk),
      .i_Rst     (i_Rst),
      .sync      (i_VSync),
      .sync_edge (vs_edge)
   );

   // A line ending on the same cycle as VSync belongs to the frame that is closing.
   assign line_len_next = sat_inc(r_HCnt);
   assign line_ok       = (line_len_next == LINE_LEN);
   assign frame_lines   = hs_edge ? sat_inc(r_VCnt) : r_VCnt;
   assign frame_good    = r_Lines_Ok && (!hs_edge || line_ok) && (frame_lines == FRAME_LINES);
   assign timeout       = (r_HCnt >= TIMEOUT_CNT);
   assign col_wrap      = !hs_edge && (o_Col == COL_LAST);
   assign lock_loss     = timeout || (hs_edge && !line_ok) || (vs_edge && !frame_good);

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_HCnt     <= '0;
         r_VCnt     <= '0;
         r_Lines_Ok <= 1'b0;
         o_Line_Len <= '0;
      end else begin
         if (hs_edge) begin
            r_HCnt     <= '0;
            o_Line_Len <= line_len_next;
         end else begin
            r_HCnt     <= line_len_next;
         end
         if (vs_edge) begin
            r_VCnt     <= '0;
            r_Lines_Ok <= 1'b1;
         end else if (hs_edge) begin
            r_VCnt <= sat_inc(r_VCnt);
            if (!line_ok) begin
               r_Lines_Ok <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         o_Col <= '0;
         o_Row <= '0;
      end else begin
         if (hs_edge) begin
            o_Col <= HS_LOAD;
         end else if (o_Col == COL_LAST) begin
            o_Col <= '0;
         end else begin
            o_Col <= o_Col + 1'b1;
         end
         if (vs_edge) begin
            o_Row <= VS_LOAD;
         end else if (col_wrap) begin
            o_Row <= (o_Row == ROW_LAST) ? '0 : o_Row + 1'b1;
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_State    <= ST_SEARCH;
         r_Good_Cnt <= '0;
         o_Locked   <= 1'b0;
         o_Error    <= 1'b0;
      end else begin
         r_State    <= next_state;
         r_Good_Cnt <= good_cnt_next;
         o_Locked   <= locked_next;
         o_Error    <= error_next;
      end
   end

   always_comb begin
      next_state    = r_State;
      good_cnt_next = r_Good_Cnt;
      case (r_State)
         ST_SEARCH: begin
            if (vs_edge) begin
               next_state    = ST_TRACK;
               good_cnt_next = '0;
            end
         end
         ST_TRACK: begin
            if (timeout) begin
               next_state = ST_SEARCH;
            end else if (vs_edge) begin
               if (frame_good) begin
                  good_cnt_next = 4'(r_Good_Cnt + 4'd1);
                  if (good_cnt_next == LOCK_CNT) begin
                     next_state = ST_LOCKED;
                  end
               end else begin
                  good_cnt_next = '0;
               end
            end
         end
         ST_LOCKED: begin
            if (lock_loss) begin
               next_state = ST_SEARCH;
            end
         end
         default: begin
            next_state = ST_SEARCH;
         end
      endcase
   end

   always_comb begin
      error_next  = (r_State == ST_LOCKED) && (next_state == ST_SEARCH);
      locked_next = (next_state == ST_LOCKED);
   end

   assign o_Active      = o_Locked && (o_Col < ACT_W) && (o_Row < ACT_H);
   assign o_Frame_Start = o_Locked && (o_Col == '0) && (o_Row == '0);

endmodule
